// File: rtl/icache_status_pkg.sv
// Constants and helpers shared by the instruction-cache status array and its
// update controller.
package icache_status_pkg;

  localparam int ADDR_WIDTH    = 4;
  localparam int NUM_ROWS      = 16;
  localparam int NUM_BLOCKS    = 4;
  localparam int BLOCK_WIDTH   = 2;
  localparam int ROW_WIDTH     = NUM_BLOCKS * BLOCK_WIDTH;
  localparam int WAY_WIDTH     = 2;
  localparam int USE_BIT_IDX   = 0;
  localparam int VALID_BIT_IDX = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ROW_WIDTH-1:0]  data;
    logic [NUM_BLOCKS-1:0] wmask;
  } wr_rec_t;

  // Overlay the masked blocks of an in-flight write onto a row read for the same set.
  function automatic logic [ROW_WIDTH-1:0] merge_rec(input logic [ROW_WIDTH-1:0]  row,
                                                     input wr_rec_t               rec,
                                                     input logic [ADDR_WIDTH-1:0] addr);
    logic [ROW_WIDTH-1:0] merged;
    merged = row;
    if (rec.valid && (rec.addr == addr)) begin
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        if (rec.wmask[b]) begin
          merged[b*BLOCK_WIDTH +: BLOCK_WIDTH] = rec.data[b*BLOCK_WIDTH +: BLOCK_WIDTH];
        end
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/status_victim_sel.sv
// Combinational hit/victim decision and status-row update for one set.
module status_victim_sel
  import icache_status_pkg::*;
(
  input  logic [ROW_WIDTH-1:0]  row,
  input  logic [NUM_BLOCKS-1:0] hit_vec,
  output logic                  hit,
  output logic [WAY_WIDTH-1:0]  way,
  output logic [ROW_WIDTH-1:0]  new_row,
  output logic [NUM_BLOCKS-1:0] wmask
);

  logic [NUM_BLOCKS-1:0] blk_valid;
  logic [NUM_BLOCKS-1:0] blk_use;
  logic [NUM_BLOCKS-1:0] sel_onehot;
  logic [NUM_BLOCKS-1:0] new_valid;
  logic [NUM_BLOCKS-1:0] new_use;
  logic                  saturated;
  logic                  hit_any;
  logic                  inv_any;
  logic                  free_any;
  logic [WAY_WIDTH-1:0]  hit_way;
  logic [WAY_WIDTH-1:0]  inv_way;
  logic [WAY_WIDTH-1:0]  free_way;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blk
      assign blk_valid[gi] = row[gi*BLOCK_WIDTH + VALID_BIT_IDX];
      assign blk_use[gi]   = row[gi*BLOCK_WIDTH + USE_BIT_IDX];
      assign new_row[gi*BLOCK_WIDTH + VALID_BIT_IDX] = new_valid[gi];
      assign new_row[gi*BLOCK_WIDTH + USE_BIT_IDX]   = new_use[gi];
    end
  endgenerate

  // Scan from the top so the lowest qualifying index is the one left standing.
  always_comb begin
    hit_any  = 1'b0;
    inv_any  = 1'b0;
    free_any = 1'b0;
    hit_way  = '0;
    inv_way  = '0;
    free_way = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_way = WAY_WIDTH'(i);
      end
      if (!blk_valid[i]) begin
        inv_any = 1'b1;
        inv_way = WAY_WIDTH'(i);
      end
      if (!blk_use[i]) begin
        free_any = 1'b1;
        free_way = WAY_WIDTH'(i);
      end
    end
  end

  assign hit = hit_any & blk_valid[hit_way];

  always_comb begin
    way = '0;
    if (hit) begin
      way = hit_way;
    end else if (inv_any) begin
      way = inv_way;
    end else if (free_any) begin
      way = free_way;
    end
  end

  assign sel_onehot = NUM_BLOCKS'(1) << way;
  // Saturation only when every other way is both valid and already used.
  assign saturated  = &((blk_valid & blk_use) | sel_onehot);
  assign new_valid  = blk_valid | sel_onehot;
  assign new_use    = saturated ? sel_onehot : (blk_use | sel_onehot);
  assign wmask      = saturated ? {NUM_BLOCKS{1'b1}} : sel_onehot;

endmodule

// File: rtl/status_update_ctrl.sv
// Instruction-cache status update controller: init sweep, hit/victim decision,
// status write-back and forwarding of its own in-flight writes.
module status_update_ctrl
  import icache_status_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_halt,
  input  logic                  i_s_valid,
  input  logic [ADDR_WIDTH-1:0] i_s_addr,
  input  logic [ROW_WIDTH-1:0]  i_s_data,
  input  logic [NUM_BLOCKS-1:0] i_s_hit,
  output logic                  o_ready,
  output logic                  o_init_done,
  output logic [ADDR_WIDTH-1:0] o_w_addr,
  output logic [ROW_WIDTH-1:0]  o_w_data,
  output logic [NUM_BLOCKS-1:0] o_w_wmask,
  output logic                  o_w_valid,
  output logic                  o_valid,
  output logic                  o_hit,
  output logic [WAY_WIDTH-1:0]  o_way
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  init_done_reg, init_done_next;
  wr_rec_t               f1_reg, f1_next;
  wr_rec_t               f2_reg, f2_next;
  logic                  valid_reg, valid_next;
  logic                  hit_reg, hit_next;
  logic [WAY_WIDTH-1:0]  way_reg, way_next;

  logic [ROW_WIDTH-1:0]  merged_row;
  logic                  sel_hit;
  logic [WAY_WIDTH-1:0]  sel_way;
  logic [ROW_WIDTH-1:0]  sel_row;
  logic [NUM_BLOCKS-1:0] sel_wmask;
  logic                  in_init;

  // Older record first so the newest write wins on overlapping blocks.
  assign merged_row = merge_rec(merge_rec(i_s_data, f2_reg, i_s_addr), f1_reg, i_s_addr);

  status_victim_sel u_victim_sel (
    .row     (merged_row),
    .hit_vec (i_s_hit),
    .hit     (sel_hit),
    .way     (sel_way),
    .new_row (sel_row),
    .wmask   (sel_wmask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_INIT;
      cnt_reg       <= '0;
      init_done_reg <= 1'b0;
      f1_reg        <= '0;
      f2_reg        <= '0;
      valid_reg     <= 1'b0;
      hit_reg       <= 1'b0;
      way_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      init_done_reg <= init_done_next;
      f1_reg        <= f1_next;
      f2_reg        <= f2_next;
      valid_reg     <= valid_next;
      hit_reg       <= hit_next;
      way_reg       <= way_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    init_done_next = init_done_reg;
    f1_next        = f1_reg;
    f2_next        = f2_reg;
    valid_next     = valid_reg;
    hit_next       = hit_reg;
    way_next       = way_reg;
    if (!i_halt) begin
      case (state_reg)
        ST_INIT: begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == ADDR_WIDTH'(NUM_ROWS - 1)) begin
            state_next     = ST_RUN;
            init_done_next = 1'b1;
          end
        end
        ST_RUN: begin
          f2_next       = f1_reg;
          f1_next.valid = i_s_valid;
          valid_next    = i_s_valid;
          if (i_s_valid) begin
            f1_next.addr  = i_s_addr;
            f1_next.data  = sel_row;
            f1_next.wmask = sel_wmask;
            hit_next      = sel_hit;
            way_next      = sel_way;
          end
        end
        default: state_next = ST_INIT;
      endcase
    end
  end

  assign in_init     = (state_reg == ST_INIT);
  assign o_ready     = ~in_init & ~i_halt;
  assign o_init_done = init_done_reg;
  assign o_valid     = valid_reg;
  assign o_hit       = hit_reg;
  assign o_way       = way_reg;
  // The sweep write is driven straight from the row counter; run-time writes come from F1.
  assign o_w_valid   = in_init ? 1'b1 : f1_reg.valid;
  assign o_w_addr    = in_init ? cnt_reg : f1_reg.addr;
  assign o_w_data    = in_init ? '0 : f1_reg.data;
  assign o_w_wmask   = in_init ? {NUM_BLOCKS{1'b1}} : f1_reg.wmask;

endmodule

// File: tb/tb_status_update_ctrl.sv
// Self-checking bench for status_update_ctrl: directed sweep/halt/reset steps
// plus randomized accesses checked against a logical status-memory model.
module tb_status_update_ctrl;
  import icache_status_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_halt;
  logic                  i_s_valid;
  logic [ADDR_WIDTH-1:0] i_s_addr;
  logic [ROW_WIDTH-1:0]  i_s_data;
  logic [NUM_BLOCKS-1:0] i_s_hit;
  logic                  o_ready;
  logic                  o_init_done;
  logic [ADDR_WIDTH-1:0] o_w_addr;
  logic [ROW_WIDTH-1:0]  o_w_data;
  logic [NUM_BLOCKS-1:0] o_w_wmask;
  logic                  o_w_valid;
  logic                  o_valid;
  logic                  o_hit;
  logic [WAY_WIDTH-1:0]  o_way;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem  [16];
  logic [7:0] hist [3][16];

  always #5 clk = ~clk;

  status_update_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_halt      (i_halt),
    .i_s_valid   (i_s_valid),
    .i_s_addr    (i_s_addr),
    .i_s_data    (i_s_data),
    .i_s_hit     (i_s_hit),
    .o_ready     (o_ready),
    .o_init_done (o_init_done),
    .o_w_addr    (o_w_addr),
    .o_w_data    (o_w_data),
    .o_w_wmask   (o_w_wmask),
    .o_w_valid   (o_w_valid),
    .o_valid     (o_valid),
    .o_hit       (o_hit),
    .o_way       (o_way)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] addr, input logic [7:0] row, input logic [3:0] hv);
    i_s_valid = 1'b1;
    i_s_addr  = addr;
    i_s_data  = row;
    i_s_hit   = hv;
  endtask

  task automatic exp_res(input string tag, input logic h, input int way,
                         input logic [7:0] data, input logic [3:0] mask, input logic [3:0] addr);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_hit"}, 32'(o_hit), 32'(h));
    chk({tag, "_way"}, 32'(o_way), 32'(way));
    chk({tag, "_wvalid"}, 32'(o_w_valid), 32'd1);
    chk({tag, "_waddr"}, 32'(o_w_addr), 32'(addr));
    chk({tag, "_wdata"}, 32'(o_w_data), 32'(data));
    chk({tag, "_wmask"}, 32'(o_w_wmask), 32'(mask));
    $display("tx %s addr=%0d hit=%0d way=%0d wdata=%02h wmask=%h", tag, addr, o_hit, o_way, o_w_data, o_w_wmask);
  endtask

  // Checks one full sweep starting at row 0; optionally halts for 3 cycles at row 6.
  task automatic sweep(input string tag, input bit with_halt);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_wvalid"}, 32'(o_w_valid), 32'd1);
      chk({tag, "_waddr"}, 32'(o_w_addr), 32'(i));
      chk({tag, "_wdata"}, 32'(o_w_data), 32'd0);
      chk({tag, "_wmask"}, 32'(o_w_wmask), 32'hF);
      chk({tag, "_done"}, 32'(o_init_done), 32'd0);
      chk({tag, "_ready"}, 32'(o_ready), 32'd0);
      $display("tx %s init write row %0d", tag, o_w_addr);
      if (with_halt && i == 6) begin
        i_halt = 1'b1;
        for (int h = 0; h < 3; h++) begin
          step();
          chk({tag, "_halt_addr"}, 32'(o_w_addr), 32'd6);
          chk({tag, "_halt_ready"}, 32'(o_ready), 32'd0);
        end
        i_halt = 1'b0;
      end
      step();
    end
    chk({tag, "_done_end"}, 32'(o_init_done), 32'd1);
    chk({tag, "_ready_end"}, 32'(o_ready), 32'd1);
    chk({tag, "_wvalid_end"}, 32'(o_w_valid), 32'd0);
  endtask

  // Status-row rules at block granularity: hit way or victim, then the use-saturation rule.
  function automatic void model(input logic [7:0] row, input logic [3:0] hv, output logic h,
                                output int way, output logic [7:0] nrow, output logic [3:0] mask);
    int v[4];
    int u[4];
    int hw;
    int busy;
    hw = -1;
    for (int b = 0; b < 4; b++) begin
      v[b] = int'(row[2*b+1]);
      u[b] = int'(row[2*b]);
      if (hv[b] && hw < 0) hw = b;
    end
    if (hw >= 0 && v[hw] == 1) begin
      h = 1'b1;
      way = hw;
    end else begin
      h = 1'b0;
      way = -1;
      for (int b = 0; b < 4; b++) if (way < 0 && v[b] == 0) way = b;
      for (int b = 0; b < 4; b++) if (way < 0 && u[b] == 0) way = b;
      if (way < 0) way = 0;
    end
    v[way] = 1;
    u[way] = 1;
    busy = 0;
    for (int b = 0; b < 4; b++) if (b != way && v[b] == 1 && u[b] == 1) busy++;
    if (busy == 3) begin
      for (int b = 0; b < 4; b++) if (b != way) u[b] = 0;
      mask = 4'hF;
    end else begin
      mask = 4'(1 << way);
    end
    nrow = '0;
    for (int b = 0; b < 4; b++) begin
      nrow[2*b+1] = v[b][0];
      nrow[2*b]   = u[b][0];
    end
  endfunction

  initial begin
    logic       m_hit;
    int         m_way;
    logic [7:0] m_row;
    logic [3:0] m_mask;
    logic       vld;
    logic [3:0] a;
    logic [3:0] hv;
    int         k;

    rst = 1'b1; i_halt = 1'b0; i_s_valid = 1'b0; i_s_addr = '0; i_s_data = '0; i_s_hit = '0;
    step();
    i_halt = 1'b1;  // reset must override halt
    step();
    i_halt = 1'b0;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_hit", 32'(o_hit), 32'd0);
    chk("rst_way", 32'(o_way), 32'd0);
    rst = 1'b0;
    sweep("init", 1'b1);

    drive(4'd3, 8'h00, 4'b0000); step();
    exp_res("miss_empty", 1'b0, 0, 8'h03, 4'h1, 4'd3);
    drive(4'd9, 8'h00, 4'b0001); step();
    exp_res("hit_invalid", 1'b0, 0, 8'h03, 4'h1, 4'd9);
    i_s_valid = 1'b0; step();
    chk("idle_valid", 32'(o_valid), 32'd0);
    chk("idle_wvalid", 32'(o_w_valid), 32'd0);

    drive(4'd5, 8'hAB, 4'b0100); step();
    exp_res("hit_w2", 1'b1, 2, 8'hBB, 4'h4, 4'd5);
    drive(4'd5, 8'hAB, 4'b0010); step();
    exp_res("hit_w1_fwd", 1'b1, 1, 8'hBF, 4'h2, 4'd5);
    drive(4'd5, 8'hAB, 4'b1000); step();
    exp_res("hit_w3_sat", 1'b1, 3, 8'hEA, 4'hF, 4'd5);
    i_s_valid = 1'b0; step();

    drive(4'd7, 8'h00, 4'b0000); step();
    exp_res("miss7_a", 1'b0, 0, 8'h03, 4'h1, 4'd7);
    drive(4'd7, 8'h00, 4'b0000); step();
    exp_res("miss7_b", 1'b0, 1, 8'h0F, 4'h2, 4'd7);
    drive(4'd7, 8'h00, 4'b0000); step();
    exp_res("miss7_c", 1'b0, 2, 8'h3F, 4'h4, 4'd7);

    drive(4'd2, 8'h55, 4'b0001);
    rst = 1'b1; step();
    rst = 1'b0; i_s_valid = 1'b0;
    chk("rrst_valid", 32'(o_valid), 32'd0);
    chk("rrst_done", 32'(o_init_done), 32'd0);
    sweep("reinit", 1'b0);

    for (int r = 0; r < 16; r++) begin
      mem[r] = '0;
      for (int d = 0; d < 3; d++) hist[d][r] = '0;
    end

    for (int it = 0; it < 400; it++) begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = mem;
      vld = ($urandom_range(0, 9) < 7);
      a   = 4'($urandom_range(0, 3));
      k   = int'($urandom_range(0, 2));
      hv  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
      if (vld) begin
        drive(a, hist[k][a], hv);
        model(mem[a], hv, m_hit, m_way, m_row, m_mask);
        mem[a] = m_row;
      end else begin
        i_s_valid = 1'b0;
        i_s_addr  = a;
        i_s_data  = 8'($urandom);
        i_s_hit   = hv;
      end
      step();
      if (vld) begin
        exp_res("rnd", m_hit, m_way, m_row, m_mask, a);
      end else begin
        chk("rnd_idle_valid", 32'(o_valid), 32'd0);
        chk("rnd_idle_wvalid", 32'(o_w_valid), 32'd0);
        $display("tx rnd idle cycle %0d", it);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
